// File: rtl/arbiter_rr_param.sv
// N-port switch arbiter: runtime fixed-priority or round-robin with burst hold and fairness cap.
// Latency 1 cycle (registered one-hot grant); a requester holds its grant while asserting req, up to MAX_HOLD cycles when others wait.
module arbiter_rr_param #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           mode,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           owner_vld_q, owner_vld_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;

    logic [N-1:0]   owner_mask;
    logic [N-1:0]   cand;
    logic           owner_req;
    logic           others_req;
    logic           under_cap;
    logic           found;
    logic [IDW-1:0] win;
    int             idx;

    always_comb begin
        gnt_d       = '0;
        gnt_id_d    = '0;
        owner_vld_d = 1'b0;
        ptr_d       = ptr_q;
        hold_d      = '0;
        cand        = req;
        found       = 1'b0;
        win         = '0;
        idx         = 0;

        // The owner index is the registered gnt_id; only meaningful while owner_vld_q.
        owner_mask = N'(1) << gnt_id_q;
        owner_req  = owner_vld_q && req[gnt_id_q];
        others_req = |(req & ~owner_mask);
        under_cap  = (MAX_HOLD == 0) || (int'(hold_q) < MAX_HOLD - 1);

        if (!mode) begin
            // Fixed priority: downward scan so the lowest set bit wins last.
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) begin
                    found = 1'b1;
                    win   = IDW'(i);
                end
            end
            if (found) begin
                gnt_d    = N'(1) << win;
                gnt_id_d = win;
            end
        end else if (owner_req && (under_cap || !others_req)) begin
            gnt_d       = gnt_q;
            gnt_id_d    = gnt_id_q;
            owner_vld_d = 1'b1;
            hold_d      = under_cap ? hold_q + HW'(1) : hold_q;
        end else begin
            if (owner_req) begin
                cand = req & ~owner_mask;
            end
            for (int i = 0; i < N; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!found && cand[idx]) begin
                    found = 1'b1;
                    win   = IDW'(idx);
                end
            end
            if (found) begin
                gnt_d       = N'(1) << win;
                gnt_id_d    = win;
                owner_vld_d = 1'b1;
                ptr_d       = (int'(win) == N - 1) ? '0 : IDW'(int'(win) + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            owner_vld_q <= 1'b0;
            ptr_q       <= '0;
            hold_q      <= '0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            owner_vld_q <= owner_vld_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_arbiter_rr_param.sv
// Directed bench for arbiter_rr_param: N=4/MAX_HOLD=8 and N=5/MAX_HOLD=2 instances.
module tb_arbiter_rr_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [3:0] req4;
    logic [3:0] gnt4;
    logic       vld4;
    logic [1:0] id4;
    logic [4:0] req5;
    logic [4:0] gnt5;
    logic       vld5;
    logic [2:0] id5;

    int errors = 0;
    int checks = 0;

    arbiter_rr_param #(.N(4), .MAX_HOLD(8)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .mode(mode),
        .gnt(gnt4), .gnt_valid(vld4), .gnt_id(id4)
    );

    arbiter_rr_param #(.N(5), .MAX_HOLD(2)) dut5 (
        .clk(clk), .rst(rst), .req(req5), .mode(mode),
        .gnt(gnt5), .gnt_valid(vld5), .gnt_id(id5)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req4 = '0;
        req5 = '0;
        mode = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        mode = 1'b1;
        req4 = 4'b1111;
        req5 = 5'b11111;
        step();
        step();
        checks++;
        if (gnt4 !== 4'b0000 || vld4 !== 1'b0 || id4 !== 2'd0) begin
            errors++;
            $display("FAIL reset_n4: gnt=%b vld=%b id=%0d expected 0000 0 0", gnt4, vld4, id4);
        end
        checks++;
        if (gnt5 !== 5'b00000 || vld5 !== 1'b0 || id5 !== 3'd0) begin
            errors++;
            $display("FAIL reset_n5: gnt=%b vld=%b id=%0d expected 00000 0 0", gnt5, vld5, id5);
        end
        rst = 1'b0;
        step();
        checks++;
        if (gnt4 !== 4'b0001 || vld4 !== 1'b1 || id4 !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%b vld=%b id=%0d expected 0001 1 0", gnt4, vld4, id4);
        end
    endtask

    task automatic test_rr_fairness();
        logic [3:0] exp_g;
        logic [1:0] exp_id;
        do_reset();
        req4 = 4'b1111;
        for (int c = 0; c < 33; c++) begin
            step();
            exp_id = 2'((c / 8) % 4);
            exp_g  = 4'b0001 << exp_id;
            checks++;
            if (gnt4 !== exp_g || id4 !== exp_id) begin
                errors++;
                $display("FAIL rr_fairness cycle %0d: gnt=%b id=%0d expected %b %0d", c, gnt4, id4, exp_g, exp_id);
            end
        end
    endtask

    task automatic test_sole_requester();
        int bad = 0;
        do_reset();
        req4 = 4'b0100;
        for (int c = 0; c < 30; c++) begin
            step();
            if (gnt4 !== 4'b0100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sole_requester: %0d of 30 cycles not 0100 (last gnt=%b)", bad, gnt4);
        end
        // Saturated owner yields at once when a second requester arrives.
        req4 = 4'b0101;
        step();
        checks++;
        if (gnt4 !== 4'b0001) begin
            errors++;
            $display("FAIL sole_then_contend: gnt=%b expected 0001", gnt4);
        end
    endtask

    task automatic test_handover();
        do_reset();
        req4 = 4'b0001;
        step();
        checks++;
        if (gnt4 !== 4'b0001) begin
            errors++;
            $display("FAIL handover_first: gnt=%b expected 0001", gnt4);
        end
        req4 = 4'b0100;
        step();
        checks++;
        if (gnt4 !== 4'b0100 || id4 !== 2'd2) begin
            errors++;
            $display("FAIL handover_next: gnt=%b id=%0d expected 0100 2", gnt4, id4);
        end
        req4 = 4'b0000;
        step();
        checks++;
        if (gnt4 !== 4'b0000 || vld4 !== 1'b0 || id4 !== 2'd0) begin
            errors++;
            $display("FAIL handover_idle: gnt=%b vld=%b id=%0d expected 0000 0 0", gnt4, vld4, id4);
        end
    endtask

    task automatic test_fixed_mode();
        do_reset();
        req4 = 4'b0100;
        step();
        checks++;
        if (gnt4 !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_setup: gnt=%b expected 0100", gnt4);
        end
        mode = 1'b0;
        req4 = 4'b1110;
        step();
        checks++;
        if (gnt4 !== 4'b0010 || id4 !== 2'd1) begin
            errors++;
            $display("FAIL fixed_lowest: gnt=%b id=%0d expected 0010 1", gnt4, id4);
        end
        req4 = 4'b1111;
        step();
        checks++;
        if (gnt4 !== 4'b0001) begin
            errors++;
            $display("FAIL fixed_req0: gnt=%b expected 0001", gnt4);
        end
        // Pointer stayed at 3 through fixed mode, so RR resumes at requester 3.
        mode = 1'b1;
        step();
        checks++;
        if (gnt4 !== 4'b1000 || id4 !== 2'd3) begin
            errors++;
            $display("FAIL fixed_to_rr: gnt=%b id=%0d expected 1000 3", gnt4, id4);
        end
        for (int c = 0; c < 7; c++) step();
        checks++;
        if (gnt4 !== 4'b1000) begin
            errors++;
            $display("FAIL rr_entry_hold: gnt=%b expected 1000", gnt4);
        end
        step();
        checks++;
        if (gnt4 !== 4'b0001) begin
            errors++;
            $display("FAIL rr_entry_cap: gnt=%b expected 0001", gnt4);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req4 = 4'b0100;
        step();
        step();
        checks++;
        if (gnt4 !== 4'b0100) begin
            errors++;
            $display("FAIL midburst_setup: gnt=%b expected 0100", gnt4);
        end
        rst = 1'b1;
        step();
        checks++;
        if (gnt4 !== 4'b0000 || vld4 !== 1'b0) begin
            errors++;
            $display("FAIL midburst_reset: gnt=%b vld=%b expected 0000 0", gnt4, vld4);
        end
        rst  = 1'b0;
        req4 = 4'b1111;
        step();
        checks++;
        if (gnt4 !== 4'b0001) begin
            errors++;
            $display("FAIL midburst_ptr_cleared: gnt=%b expected 0001", gnt4);
        end
    endtask

    task automatic test_wrap_n5();
        logic [4:0] exp_g;
        logic [2:0] exp_id;
        do_reset();
        req5 = 5'b11111;
        for (int c = 0; c < 11; c++) begin
            step();
            exp_id = 3'((c / 2) % 5);
            exp_g  = 5'b00001 << exp_id;
            checks++;
            if (gnt5 !== exp_g || id5 !== exp_id) begin
                errors++;
                $display("FAIL wrap_n5 cycle %0d: gnt=%b id=%0d expected %b %0d", c, gnt5, id5, exp_g, exp_id);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_sole_requester();
        test_handover();
        test_fixed_mode();
        test_reset_mid_burst();
        test_wrap_n5();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
